// File: rtl/aes_dec_round_sequencer.sv
// AES-128 inverse-cipher round sequencer.
// Drives the message mux, state-register loads, round-key index and InvMixColumns word select
// of an iterative decryption datapath. Optional cycle counter enabled by AES_SEQ_PERF_CNT_EN.
`timescale 1ns/1ps

module aes_dec_round_sequencer #(
   parameter int unsigned KEY_EXP_CYCLES = 12,
   parameter int unsigned SUB_LAT        = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       AES_START,
   output logic       AES_DONE,
   output logic       BUSY,
   output logic       LOAD_MSG,
   output logic       LOAD_RG,
   output logic [1:0] MSG_MUX,
   output logic [1:0] INV_MUX,
   output logic [3:0] ROUND_IDX
`ifdef AES_SEQ_PERF_CNT_EN
   ,
   output logic [15:0] PERF_CYCLES
`endif
);

   // Wait counter only has to hold the larger of the two waits, minus one.
   localparam int unsigned WaitMax = (KEY_EXP_CYCLES > SUB_LAT) ? KEY_EXP_CYCLES : SUB_LAT;
   localparam int unsigned CntW    = (WaitMax > 1) ? $clog2(WaitMax) : 1;

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StLoadCt  = 4'd1,
      StKeyWait = 4'd2,
      StArk     = 4'd3,
      StIsr     = 4'd4,
      StIsbW    = 4'd5,
      StIsb     = 4'd6,
      StImc0    = 4'd7,
      StImc1    = 4'd8,
      StImc2    = 4'd9,
      StImc3    = 4'd10,
      StImcLd   = 4'd11,
      StDone    = 4'd12
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        rnd_q, rnd_d;
   logic [CntW-1:0]   wcnt_q, wcnt_d;

   logic              done_d, busy_d, load_msg_d, load_rg_d;
   logic [1:0]        msg_mux_d, inv_mux_d;
   logic [3:0]        round_idx_d;

   // Next-state, round counter and wait counter.
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         StIdle: begin
            if (AES_START) state_d = StLoadCt;
         end
         StLoadCt: begin
            state_d = StKeyWait;
            wcnt_d  = CntW'(KEY_EXP_CYCLES - 1);
         end
         StKeyWait: begin
            if (wcnt_q == '0) begin
               state_d = StArk;
               rnd_d   = 4'd10;
            end else begin
               wcnt_d = wcnt_q - 1'b1;
            end
         end
         StArk: begin
            if (rnd_q == 4'd10)     state_d = StIsr;
            else if (rnd_q == 4'd0) state_d = StDone;
            else                    state_d = StImc0;
            if (rnd_q != 4'd0) rnd_d = rnd_q - 4'd1;
         end
         StIsr: begin
            state_d = StIsbW;
            wcnt_d  = CntW'(SUB_LAT - 1);
         end
         StIsbW: begin
            if (wcnt_q == '0) state_d = StIsb;
            else              wcnt_d  = wcnt_q - 1'b1;
         end
         StIsb:   state_d = StArk;
         StImc0:  state_d = StImc1;
         StImc1:  state_d = StImc2;
         StImc2:  state_d = StImc3;
         StImc3:  state_d = StImcLd;
         StImcLd: state_d = StIsr;
         StDone: begin
            if (!AES_START) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            rnd_d   = 4'd0;
            wcnt_d  = '0;
         end
      endcase
   end

   // Output decode from the next state so every output is a plain register.
   always_comb begin
      done_d      = (state_d == StDone);
      busy_d      = (state_d != StIdle) && (state_d != StDone);
      load_msg_d  = (state_d == StLoadCt);
      load_rg_d   = (state_d == StArk) || (state_d == StIsr) || (state_d == StIsb) ||
                    (state_d == StImcLd);
      msg_mux_d   = 2'b00;
      inv_mux_d   = 2'd0;
      round_idx_d = 4'd0;
      case (state_d)
         StArk:            round_idx_d = rnd_d;
         StIsr:            msg_mux_d   = 2'b01;
         StIsbW, StIsb:    msg_mux_d   = 2'b11;
         // IMC word states keep the mux on InvMixColumns so the word decoder sees its source.
         StImc0:           msg_mux_d   = 2'b10;
         StImc1: begin
            msg_mux_d = 2'b10;
            inv_mux_d = 2'd1;
         end
         StImc2: begin
            msg_mux_d = 2'b10;
            inv_mux_d = 2'd2;
         end
         StImc3: begin
            msg_mux_d = 2'b10;
            inv_mux_d = 2'd3;
         end
         StImcLd:          msg_mux_d   = 2'b10;
         default:          msg_mux_d   = 2'b00;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= StIdle;
         rnd_q     <= 4'd0;
         wcnt_q    <= '0;
         AES_DONE  <= 1'b0;
         BUSY      <= 1'b0;
         LOAD_MSG  <= 1'b0;
         LOAD_RG   <= 1'b0;
         MSG_MUX   <= 2'b00;
         INV_MUX   <= 2'd0;
         ROUND_IDX <= 4'd0;
      end else begin
         state_q   <= state_d;
         rnd_q     <= rnd_d;
         wcnt_q    <= wcnt_d;
         AES_DONE  <= done_d;
         BUSY      <= busy_d;
         LOAD_MSG  <= load_msg_d;
         LOAD_RG   <= load_rg_d;
         MSG_MUX   <= msg_mux_d;
         INV_MUX   <= inv_mux_d;
         ROUND_IDX <= round_idx_d;
      end
   end

`ifdef AES_SEQ_PERF_CNT_EN
   logic [15:0] perf_q;

   // Busy-cycle counter: cleared on a new start, saturating, frozen while idle or done.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         perf_q <= 16'd0;
      end else if ((state_q == StIdle) && (state_d == StLoadCt)) begin
         perf_q <= 16'd0;
      end else if (BUSY && (perf_q != 16'hFFFF)) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign PERF_CYCLES = perf_q;
`endif

endmodule

// File: tb/tb_aes_dec_round_sequencer.sv
// Bench for aes_dec_round_sequencer: drives a behavioural AES-128 decryption datapath with two
// sequencer instances (default parameters and KEY_EXP_CYCLES=1/SUB_LAT=2).
// Define AES_SEQ_PERF_CNT_EN to also exercise the cycle counter.
`timescale 1ns/1ps

module tb_aes_dec_round_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start_a, start_b;
   logic done_a, busy_a, lmsg_a, lrg_a;
   logic [1:0] mux_a, inv_a;
   logic [3:0] idx_a;
   logic done_b, busy_b, lmsg_b, lrg_b;
   logic [1:0] mux_b, inv_b;
   logic [3:0] idx_b;
`ifdef AES_SEQ_PERF_CNT_EN
   logic [15:0] perf_a, perf_b;
`endif

   aes_dec_round_sequencer u_dut_a (
      .CLK       (clk),
      .RESET     (rst),
      .AES_START (start_a),
      .AES_DONE  (done_a),
      .BUSY      (busy_a),
      .LOAD_MSG  (lmsg_a),
      .LOAD_RG   (lrg_a),
      .MSG_MUX   (mux_a),
      .INV_MUX   (inv_a),
      .ROUND_IDX (idx_a)
`ifdef AES_SEQ_PERF_CNT_EN
      ,
      .PERF_CYCLES (perf_a)
`endif
   );

   aes_dec_round_sequencer #(
      .KEY_EXP_CYCLES (1),
      .SUB_LAT        (2)
   ) u_dut_b (
      .CLK       (clk),
      .RESET     (rst),
      .AES_START (start_b),
      .AES_DONE  (done_b),
      .BUSY      (busy_b),
      .LOAD_MSG  (lmsg_b),
      .LOAD_RG   (lrg_b),
      .MSG_MUX   (mux_b),
      .INV_MUX   (inv_b),
      .ROUND_IDX (idx_b)
`ifdef AES_SEQ_PERF_CNT_EN
      ,
      .PERF_CYCLES (perf_b)
`endif
   );

   localparam logic [127:0] Key = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] Pt  = 128'h00112233445566778899aabbccddeeff;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- AES reference arithmetic ----------------
   logic [7:0]    sbox  [256];
   logic [7:0]    isbox [256];
   logic [1407:0] rk_all;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            for (int y = 1; y < 256; y++) begin
               if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
         end
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         sbox[x]  = s;
         isbox[s] = 8'(x);
      end
   endtask

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i - 4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk_all[128 * r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8 * (4 * ((c + r) % 4) + r) -: 8] = s[127 - 8 * (4 * c + r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int b = 0; b < 16; b++) o[127 - 8 * b -: 8] = isbox[s[127 - 8 * b -: 8]];
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

   // ---------------- behavioural datapaths ----------------
   logic [127:0] st_a, imc_a, st_b, imc_b;

   always @(posedge clk) begin
      if (lmsg_a) st_a <= Ct;
      else if (lrg_a) begin
         case (mux_a)
            2'b00:   st_a <= st_a ^ rk_all[128 * idx_a +: 128];
            2'b01:   st_a <= inv_shift_rows(st_a);
            2'b11:   st_a <= inv_sub_bytes(st_a);
            default: st_a <= imc_a;
         endcase
      end else if (mux_a == 2'b10) imc_a[32 * inv_a +: 32] <= inv_mix_word(st_a[32 * inv_a +: 32]);
   end

   always @(posedge clk) begin
      if (lmsg_b) st_b <= Ct;
      else if (lrg_b) begin
         case (mux_b)
            2'b00:   st_b <= st_b ^ rk_all[128 * idx_b +: 128];
            2'b01:   st_b <= inv_shift_rows(st_b);
            2'b11:   st_b <= inv_sub_bytes(st_b);
            default: st_b <= imc_b;
         endcase
      end else if (mux_b == 2'b10) imc_b[32 * inv_b +: 32] <= inv_mix_word(st_b[32 * inv_b +: 32]);
   end

   // ---------------- sequence monitor on instance A ----------------
   logic mon_en = 1'b0;
   int   n_lrg = 0, n_lmsg = 0, n_ark = 0, ark_bad = 0, both_bad = 0;
   int   n_inv [4] = '{0, 0, 0, 0};

   always @(negedge clk) begin
      if (mon_en) begin
         if (lrg_a) n_lrg <= n_lrg + 1;
         if (lmsg_a) n_lmsg <= n_lmsg + 1;
         if (lrg_a && lmsg_a) both_bad <= both_bad + 1;
         if (lrg_a && mux_a == 2'b00) begin
            if (idx_a != 4'(10 - n_ark)) ark_bad <= ark_bad + 1;
            n_ark <= n_ark + 1;
         end
         if (!lrg_a && mux_a == 2'b10) n_inv[inv_a] <= n_inv[inv_a] + 1;
      end
   end

   // Counts edges (checking #1 after each) until the selected AES_DONE is high; bounded.
   task automatic wait_done(input logic sel, input int lat0, output int lat);
      lat = lat0;
      while (((sel ? done_b : done_a) !== 1'b1) && lat < 400) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   int lat, k;

   initial begin
      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      build_sbox();
      expand_key(Key);
      repeat (3) @(negedge clk);

      check_eq("rst_done", done_a, 0);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_lmsg", lmsg_a, 0);
      check_eq("rst_lrg", lrg_a, 0);
      check_eq("rst_mux", mux_a, 0);
      check_eq("rst_inv", inv_a, 0);
      check_eq("rst_idx", idx_a, 0);
      @(negedge clk);
      rst = 1'b0;

      // Known-answer run with the sequence monitor, START held throughout
      @(negedge clk);
      mon_en  = 1'b1;
      start_a = 1'b1;
      @(posedge clk);
      #1;
      wait_done(1'b0, 0, lat);
      check_eq("lat_a", lat, 99);
      check_eq("pt_a", st_a, Pt);
      @(negedge clk);
      mon_en = 1'b0;
      check_eq("n_load_rg", n_lrg, 40);
      check_eq("n_load_msg", n_lmsg, 1);
      check_eq("n_ark", n_ark, 11);
      check_eq("ark_idx_order", ark_bad, 0);
      check_eq("load_overlap", both_bad, 0);
      for (int i = 0; i < 4; i++) check_eq($sformatf("inv_mux_%0d", i), n_inv[i], 9);
`ifdef AES_SEQ_PERF_CNT_EN
      check_eq("perf_run", perf_a, 99);
`endif

      // START held in DONE: stays done, no restart
      repeat (5) @(posedge clk);
      #1;
      check_eq("hold_done", done_a, 1);
      check_eq("hold_busy", busy_a, 0);
      check_eq("hold_lmsg", lmsg_a, 0);
      start_a = 1'b0;
      @(posedge clk);
      #1;
      check_eq("drop_done", done_a, 0);
      check_eq("drop_busy", busy_a, 0);

      // New run, START dropped at cycle 30: completes, AES_DONE high one cycle
      start_a = 1'b1;
      @(posedge clk);
      #1;
`ifdef AES_SEQ_PERF_CNT_EN
      check_eq("perf_clear", perf_a, 0);
`endif
      lat = 0;
      while (lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
      end
      start_a = 1'b0;
      wait_done(1'b0, lat, lat);
      check_eq("lat_drop", lat, 99);
      check_eq("pt_drop", st_a, Pt);
      @(posedge clk);
      #1;
      check_eq("pulse_done", done_a, 0);
      check_eq("pulse_busy", busy_a, 0);

      // Instance B: KEY_EXP_CYCLES=1, SUB_LAT=2
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      wait_done(1'b1, 0, lat);
      check_eq("lat_b", lat, 98);
      check_eq("pt_b", st_b, Pt);
      start_b = 1'b0;

      // Asynchronous reset while A sits in IMC2
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      k = 0;
      while (!(inv_a == 2'd2 && mux_a == 2'b10 && !lrg_a) && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_eq("reach_imc2", (k < 200), 1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_busy", busy_a, 0);
      check_eq("arst_inv", inv_a, 0);
      check_eq("arst_mux", mux_a, 0);
      check_eq("arst_lrg", lrg_a, 0);
      check_eq("arst_done", done_a, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("idle_busy", busy_a, 0);
      check_eq("idle_lmsg", lmsg_a, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
